// File: rtl/core_if_ifu.sv
// Instruction fetch unit: sequential fetch issue, in-order response pairing,
// static BTFN/JAL prediction and a 2-entry decoupling queue towards decode.
`ifndef CORE_PC_WIDTH
`define CORE_PC_WIDTH 32
`endif
`ifndef CORE_INST_WIDTH
`define CORE_INST_WIDTH 32
`endif

module core_if_ifu #(
   parameter int unsigned         PC_WIDTH   = `CORE_PC_WIDTH,
   parameter int unsigned         INST_WIDTH = `CORE_INST_WIDTH,
   parameter logic [PC_WIDTH-1:0] RESET_PC   = PC_WIDTH'(32'h8000_0000)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  i_redirect_valid,
   input  logic [PC_WIDTH-1:0]   i_redirect_pc,
   output logic                  o_imem_req_valid,
   input  logic                  i_imem_req_ready,
   output logic [PC_WIDTH-1:0]   o_imem_req_addr,
   input  logic                  i_imem_rsp_valid,
   input  logic [INST_WIDTH-1:0] i_imem_rsp_data,
   output logic                  o_valid,
   input  logic                  i_ready,
   output logic [PC_WIDTH-1:0]   o_pc,
   output logic [INST_WIDTH-1:0] o_inst,
   output logic                  o_branch_predict
);
   localparam int unsigned      CNT_W      = 2;
   localparam int unsigned      CRED_W     = 3;
   localparam int unsigned      BIMM_W     = 13;
   localparam int unsigned      JIMM_W     = 21;
   localparam logic [6:0]       OPC_BRANCH = 7'b1100011;
   localparam logic [6:0]       OPC_JAL    = 7'b1101111;
   localparam logic [CNT_W-1:0] DEPTH      = CNT_W'(2);

   typedef struct packed {
      logic [PC_WIDTH-1:0]   pc;
      logic [INST_WIDTH-1:0] inst;
      logic                  pred;
   } out_entry_t;

   logic [PC_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
   logic [CNT_W-1:0]    outstanding_q, outstanding_d;
   logic [CNT_W-1:0]    kill_q, kill_d;

   logic [PC_WIDTH-1:0] ifl_pc_q [2];
   logic                ifl_wr_q, ifl_wr_d;
   logic                ifl_rd_q, ifl_rd_d;

   out_entry_t          out_mem_q [2];
   logic                out_wr_q, out_wr_d;
   logic                out_rd_q, out_rd_d;
   logic [CNT_W-1:0]    occ_q, occ_d;

   logic                pop;
   logic                rsp_acc;
   logic                rsp_live;
   logic                push;
   logic                issue;
   logic                pred_hit;
   logic                pred_taken_now;
   logic [PC_WIDTH-1:0] rsp_pc;
   logic [PC_WIDTH-1:0] pred_target;
   logic [CRED_W-1:0]   credit_used;
   logic [6:0]          opcode;
   logic [BIMM_W-1:0]   b_imm;
   logic [JIMM_W-1:0]   j_imm;
   out_entry_t          push_entry;

   // Response pairing and static prediction on the live (non-killed) response
   always_comb begin
      pop      = (occ_q != '0) && i_ready;
      rsp_acc  = i_imem_rsp_valid && (outstanding_q != '0);
      rsp_live = rsp_acc && (kill_q == '0);
      rsp_pc   = ifl_pc_q[ifl_rd_q];

      opcode   = i_imem_rsp_data[6:0];
      b_imm    = {i_imem_rsp_data[31], i_imem_rsp_data[7], i_imem_rsp_data[30:25],
                  i_imem_rsp_data[11:8], 1'b0};
      j_imm    = {i_imem_rsp_data[31], i_imem_rsp_data[19:12], i_imem_rsp_data[20],
                  i_imem_rsp_data[30:21], 1'b0};

      pred_hit = (opcode == OPC_JAL) || ((opcode == OPC_BRANCH) && i_imem_rsp_data[31]);
      if (opcode == OPC_JAL)
         pred_target = rsp_pc + {{(PC_WIDTH-JIMM_W){j_imm[JIMM_W-1]}}, j_imm};
      else
         pred_target = rsp_pc + {{(PC_WIDTH-BIMM_W){b_imm[BIMM_W-1]}}, b_imm};

      pred_taken_now = rsp_live && pred_hit;
      push           = rsp_live && !i_redirect_valid;
      push_entry     = '{pc: rsp_pc, inst: i_imem_rsp_data, pred: pred_hit};
   end

   // Credit-based issue: queued entries plus in-flight requests never exceed two
   always_comb begin
      credit_used      = CRED_W'(occ_q) + CRED_W'(outstanding_q) - CRED_W'(pop);
      o_imem_req_valid = !rst && !i_redirect_valid && !pred_taken_now
                         && (credit_used < CRED_W'(2));
      o_imem_req_addr  = fetch_pc_q;
      issue            = o_imem_req_valid && i_imem_req_ready;
   end

   // Fetch PC, in-flight tracking and kill count; redirect beats prediction
   always_comb begin
      fetch_pc_d    = fetch_pc_q;
      kill_d        = kill_q;
      outstanding_d = outstanding_q + CNT_W'(issue) - CNT_W'(rsp_acc);
      ifl_wr_d      = ifl_wr_q ^ issue;
      ifl_rd_d      = ifl_rd_q ^ rsp_acc;

      if (i_redirect_valid) begin
         fetch_pc_d = i_redirect_pc;
         kill_d     = outstanding_q - CNT_W'(rsp_acc);
      end else if (pred_taken_now) begin
         fetch_pc_d = pred_target;
         kill_d     = outstanding_q - CNT_W'(1);
      end else begin
         if (issue)
            fetch_pc_d = fetch_pc_q + PC_WIDTH'(4);
         if (rsp_acc && (kill_q != '0))
            kill_d = kill_q - CNT_W'(1);
      end
   end

   // Output queue bookkeeping; a redirect empties it
   always_comb begin
      occ_d    = occ_q;
      out_wr_d = out_wr_q;
      out_rd_d = out_rd_q;
      if (i_redirect_valid) begin
         occ_d    = '0;
         out_wr_d = 1'b0;
         out_rd_d = 1'b0;
      end else begin
         occ_d    = occ_q + CNT_W'(push) - CNT_W'(pop);
         out_wr_d = out_wr_q ^ push;
         out_rd_d = out_rd_q ^ pop;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_pc_q    <= RESET_PC;
         outstanding_q <= '0;
         kill_q        <= '0;
         ifl_wr_q      <= 1'b0;
         ifl_rd_q      <= 1'b0;
         ifl_pc_q[0]   <= '0;
         ifl_pc_q[1]   <= '0;
         occ_q         <= '0;
         out_wr_q      <= 1'b0;
         out_rd_q      <= 1'b0;
         out_mem_q[0]  <= '0;
         out_mem_q[1]  <= '0;
      end else begin
         fetch_pc_q    <= fetch_pc_d;
         outstanding_q <= outstanding_d;
         kill_q        <= kill_d;
         ifl_wr_q      <= ifl_wr_d;
         ifl_rd_q      <= ifl_rd_d;
         occ_q         <= occ_d;
         out_wr_q      <= out_wr_d;
         out_rd_q      <= out_rd_d;
         if (issue)
            ifl_pc_q[ifl_wr_q] <= fetch_pc_q;
         if (push)
            out_mem_q[out_wr_q] <= push_entry;
      end
   end

   // The credit rule makes both of these unreachable
   always_ff @(posedge clk) begin
      if (!rst) begin
         assert (!(push && !pop && (occ_q == DEPTH)));
         assert (!(issue && !rsp_acc && (outstanding_q == DEPTH)));
      end
   end

   assign o_valid          = (occ_q != '0);
   assign o_pc             = out_mem_q[out_rd_q].pc;
   assign o_inst           = out_mem_q[out_rd_q].inst;
   assign o_branch_predict = out_mem_q[out_rd_q].pred;

endmodule

// File: tb/tb_core_if_ifu.sv
// Self-checking bench for core_if_ifu: in-order memory model with programmable
// latency, a prediction vector table and hand-written multi-cycle sequences.
module tb_core_if_ifu;
   localparam logic [31:0] NOP = 32'h0000_0013;
   localparam logic [31:0] BAD = 32'hDEAD_BEEF;

   logic        clk = 1'b0;
   logic        rst;
   logic        i_redirect_valid;
   logic [31:0] i_redirect_pc;
   logic        o_imem_req_valid;
   logic        i_imem_req_ready;
   logic [31:0] o_imem_req_addr;
   logic        i_imem_rsp_valid;
   logic [31:0] i_imem_rsp_data;
   logic        o_valid;
   logic        i_ready;
   logic [31:0] o_pc;
   logic [31:0] o_inst;
   logic        o_branch_predict;

   always #5 clk = ~clk;

   core_if_ifu #(.PC_WIDTH(32), .INST_WIDTH(32), .RESET_PC(32'h8000_0000)) dut (
      .clk              (clk),
      .rst              (rst),
      .i_redirect_valid (i_redirect_valid),
      .i_redirect_pc    (i_redirect_pc),
      .o_imem_req_valid (o_imem_req_valid),
      .i_imem_req_ready (i_imem_req_ready),
      .o_imem_req_addr  (o_imem_req_addr),
      .i_imem_rsp_valid (i_imem_rsp_valid),
      .i_imem_rsp_data  (i_imem_rsp_data),
      .o_valid          (o_valid),
      .i_ready          (i_ready),
      .o_pc             (o_pc),
      .o_inst           (o_inst),
      .o_branch_predict (o_branch_predict)
   );

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
      logic        pred;
   } ent_t;

   typedef struct {
      logic [31:0] addr;
      int          due;
   } req_t;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] inst;
      logic        exp_pred;
      logic [31:0] exp_next;
   } vec_t;

   int          n_tests = 0;
   int          n_fail  = 0;
   int          cyc     = 0;
   int          lat     = 1;
   int          first_valid_cyc = -1;
   logic [31:0] prog_addr = '0;
   logic [31:0] prog_data = NOP;
   req_t        mem_q[$];
   logic [31:0] iss_q[$];
   int          iss_cyc[$];
   ent_t        out_q[$];
   logic        hold_prev = 1'b0;
   ent_t        hold_ent;
   vec_t        vecs [8];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] iss_at(input int i);
      return (i < iss_q.size()) ? iss_q[i] : BAD;
   endfunction

   function automatic ent_t out_at(input int i);
      ent_t e;
      e = '{pc: BAD, inst: BAD, pred: 1'bx};
      if (i < out_q.size()) e = out_q[i];
      return e;
   endfunction

   function automatic int count_out_pc(input logic [31:0] pc);
      int n = 0;
      foreach (out_q[k]) if (out_q[k].pc == pc) n++;
      return n;
   endfunction

   function automatic int count_iss(input logic [31:0] a);
      int n = 0;
      foreach (iss_q[k]) if (iss_q[k] == a) n++;
      return n;
   endfunction

   // Memory response driver: in order, fixed latency, single program word
   always @(posedge clk) begin
      cyc = cyc + 1;
      #1;
      if (mem_q.size() != 0 && mem_q[0].due <= cyc) begin
         i_imem_rsp_valid = 1'b1;
         i_imem_rsp_data  = (mem_q[0].addr == prog_addr) ? prog_data : NOP;
         void'(mem_q.pop_front());
      end else begin
         i_imem_rsp_valid = 1'b0;
         i_imem_rsp_data  = '0;
      end
   end

   // Monitor: log accepted requests and ID transfers, check head stability
   always @(negedge clk) begin
      if (rst) begin
         hold_prev = 1'b0;
      end else begin
         if (o_imem_req_valid && i_imem_req_ready) begin
            iss_q.push_back(o_imem_req_addr);
            iss_cyc.push_back(cyc);
            mem_q.push_back('{addr: o_imem_req_addr, due: cyc + lat});
         end
         if (o_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
         if (hold_prev && o_valid) begin
            n_tests++;
            if ({o_pc, o_inst, o_branch_predict} !== hold_ent) begin
               n_fail++;
               $display("FAIL hold_stable: got pc=0x%08h inst=0x%08h, expected pc=0x%08h inst=0x%08h",
                        o_pc, o_inst, hold_ent.pc, hold_ent.inst);
            end
         end
         if (o_valid && i_ready) out_q.push_back('{pc: o_pc, inst: o_inst, pred: o_branch_predict});
         hold_prev = o_valid && !i_ready && !i_redirect_valid;
         hold_ent  = '{pc: o_pc, inst: o_inst, pred: o_branch_predict};
      end
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic sample();
      @(negedge clk);
      #1;
   endtask

   task automatic clear_logs();
      mem_q.delete();
      iss_q.delete();
      iss_cyc.delete();
      out_q.delete();
      first_valid_cyc = -1;
   endtask

   // Returns just after the edge that starts the first post-reset cycle
   task automatic do_reset();
      @(posedge clk);
      #1;
      rst = 1'b1;
      i_redirect_valid = 1'b0;
      repeat (2) begin
         sample();
         clear_logs();
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      vecs[0] = '{pc: 32'h8000_0010, inst: 32'hFE00_0EE3, exp_pred: 1'b1, exp_next: 32'h8000_000C};
      vecs[1] = '{pc: 32'h8000_0040, inst: 32'h0000_0463, exp_pred: 1'b0, exp_next: 32'h8000_0044};
      vecs[2] = '{pc: 32'h8000_0000, inst: 32'h0200_006F, exp_pred: 1'b1, exp_next: 32'h8000_0020};
      vecs[3] = '{pc: 32'h8000_0100, inst: 32'hFF9F_F06F, exp_pred: 1'b1, exp_next: 32'h8000_00F8};
      vecs[4] = '{pc: 32'h8000_0200, inst: 32'hFE00_0EB3, exp_pred: 1'b0, exp_next: 32'h8000_0204};
      vecs[5] = '{pc: 32'hFFFF_FFFC, inst: NOP,          exp_pred: 1'b0, exp_next: 32'h0000_0000};
      vecs[6] = '{pc: 32'hFFFF_FFF0, inst: 32'h0200_006F, exp_pred: 1'b1, exp_next: 32'h0000_0010};
      vecs[7] = '{pc: 32'h8000_0080, inst: 32'hFE00_0EE3, exp_pred: 1'b1, exp_next: 32'h8000_007C};

      rst = 1'b1;
      i_redirect_valid = 1'b0;
      i_redirect_pc    = '0;
      i_imem_req_ready = 1'b1;
      i_imem_rsp_valid = 1'b0;
      i_imem_rsp_data  = '0;
      i_ready          = 1'b1;

      // Reset state
      repeat (3) @(posedge clk);
      sample();
      chk("rst_o_valid", 32'(o_valid), 32'd0);
      chk("rst_req_valid", 32'(o_imem_req_valid), 32'd0);
      chk("rst_o_pc", o_pc, 32'd0);
      chk("rst_o_inst", o_inst, 32'd0);
      chk("rst_o_pred", 32'(o_branch_predict), 32'd0);

      // Reset then stream, 1-cycle memory
      lat = 1; i_ready = 1'b1; prog_addr = 32'h0000_0004; prog_data = NOP;
      do_reset();
      step(6);
      sample();
      chk("stream_iss0", iss_at(0), 32'h8000_0000);
      chk("stream_iss1", iss_at(1), 32'h8000_0004);
      chk("stream_iss2", iss_at(2), 32'h8000_0008);
      chk("stream_iss_gap01", 32'((iss_cyc.size() > 2) ? iss_cyc[1] - iss_cyc[0] : -1), 32'd1);
      chk("stream_iss_gap12", 32'((iss_cyc.size() > 2) ? iss_cyc[2] - iss_cyc[1] : -1), 32'd1);
      chk("stream_first_valid", 32'((iss_cyc.size() > 0) ? first_valid_cyc - iss_cyc[0] : -1), 32'd2);
      chk("stream_out3_pc", out_at(3).pc, 32'h8000_000C);

      // ID stall for 10 cycles
      lat = 1; i_ready = 1'b0;
      do_reset();
      step(10);
      sample();
      chk("stall_iss_count", 32'(iss_q.size()), 32'd2);
      chk("stall_req_valid", 32'(o_imem_req_valid), 32'd0);
      chk("stall_o_valid", 32'(o_valid), 32'd1);
      chk("stall_head_pc", o_pc, 32'h8000_0000);
      chk("stall_head_inst", o_inst, NOP);
      step(1);
      i_ready = 1'b1;
      step(4);
      sample();
      chk("stall_out0_pc", out_at(0).pc, 32'h8000_0000);
      chk("stall_out1_pc", out_at(1).pc, 32'h8000_0004);

      // Redirect timing while streaming
      lat = 1; i_ready = 1'b1;
      do_reset();
      step(6);
      i_redirect_valid = 1'b1;
      i_redirect_pc    = 32'h8000_0400;
      sample();
      chk("redir_pre_valid", 32'(o_valid), 32'd1);
      begin
         int n0;
         n0 = out_q.size();
         step(1);
         i_redirect_valid = 1'b0;
         sample();
         chk("redir_post_valid", 32'(o_valid), 32'd0);
         chk("redir_post_req_valid", 32'(o_imem_req_valid), 32'd1);
         chk("redir_post_req_addr", o_imem_req_addr, 32'h8000_0400);
         step(4);
         sample();
         chk("redir_next_out_pc", out_at(n0).pc, 32'h8000_0400);
      end

      // Redirect with two outstanding requests, 3-cycle memory
      lat = 3; i_ready = 1'b1;
      do_reset();
      begin
         int k;
         k = 0;
         while (iss_q.size() < 2 && k < 20) begin
            sample();
            k++;
         end
      end
      chk("lat3_two_issued", 32'(iss_q.size()), 32'd2);
      step(1);
      i_redirect_valid = 1'b1;
      i_redirect_pc    = 32'h8000_0100;
      step(1);
      i_redirect_valid = 1'b0;
      step(15);
      sample();
      chk("lat3_iss2", iss_at(2), 32'h8000_0100);
      chk("lat3_out0_pc", out_at(0).pc, 32'h8000_0100);
      chk("lat3_old0_dropped", 32'(count_out_pc(32'h8000_0000)), 32'd0);
      chk("lat3_old4_dropped", 32'(count_out_pc(32'h8000_0004)), 32'd0);

      // Backward branch with a younger request in flight, 2-cycle memory
      lat = 2; i_ready = 1'b1; prog_addr = 32'h8000_0010; prog_data = 32'hFE00_0EE3;
      do_reset();
      step(16);
      sample();
      chk("bwd_iss5", iss_at(5), 32'h8000_0014);
      chk("bwd_iss6", iss_at(6), 32'h8000_000C);
      chk("bwd_out4_pc", out_at(4).pc, 32'h8000_0010);
      chk("bwd_out4_inst", out_at(4).inst, 32'hFE00_0EE3);
      chk("bwd_out4_pred", 32'(out_at(4).pred), 32'd1);
      chk("bwd_out5_pc", out_at(5).pc, 32'h8000_000C);
      chk("bwd_young_dropped", 32'(count_out_pc(32'h8000_0014)), 32'd0);

      // Redirect in the same cycle as a predicted-taken JAL response
      lat = 1; i_ready = 1'b1; prog_addr = 32'h8000_0000; prog_data = 32'h0200_006F;
      do_reset();
      step(1);
      i_redirect_valid = 1'b1;
      i_redirect_pc    = 32'h8000_0300;
      step(1);
      i_redirect_valid = 1'b0;
      step(6);
      sample();
      chk("both_iss0", iss_at(0), 32'h8000_0000);
      chk("both_iss1", iss_at(1), 32'h8000_0300);
      chk("both_out0_pc", out_at(0).pc, 32'h8000_0300);
      chk("both_out0_pred", 32'(out_at(0).pred), 32'd0);
      chk("both_jal_dropped", 32'(count_out_pc(32'h8000_0000)), 32'd0);
      chk("both_no_jal_target", 32'(count_iss(32'h8000_0020)), 32'd0);

      // Prediction vector table: redirect to pc, check entry and next fetch
      for (int i = 0; i < 8; i++) begin
         lat = 1; i_ready = 1'b1;
         prog_addr = vecs[i].pc;
         prog_data = vecs[i].inst;
         do_reset();
         i_redirect_valid = 1'b1;
         i_redirect_pc    = vecs[i].pc;
         step(1);
         i_redirect_valid = 1'b0;
         step(6);
         sample();
         chk($sformatf("vec%0d_iss0", i), iss_at(0), vecs[i].pc);
         chk($sformatf("vec%0d_next_fetch", i), iss_at(1), vecs[i].exp_next);
         chk($sformatf("vec%0d_out_pc", i), out_at(0).pc, vecs[i].pc);
         chk($sformatf("vec%0d_out_inst", i), out_at(0).inst, vecs[i].inst);
         chk($sformatf("vec%0d_out_pred", i), 32'(out_at(0).pred), 32'(vecs[i].exp_pred));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/core_if_ifu.md
# core_if_ifu

Instruction fetch unit. It generates sequential fetch addresses, issues them to instruction memory, and pairs each in-order response with its PC. It applies a static BTFN/JAL prediction and delivers `{pc, inst, branch_predict}` to the decode stage over a valid/ready handshake. The block sits between the instruction memory port and the ID stage, and absorbs execute-stage redirects by flushing in-flight work.

## Interface
- `PC_WIDTH`, default `` `CORE_PC_WIDTH `` (32): fetch address width.
- `INST_WIDTH`, default `` `CORE_INST_WIDTH `` (32): instruction width.
- `RESET_PC`, default `32'h8000_0000`: first fetch address after reset.
- `clk`, in, 1: the only clock. All state updates on its rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `i_redirect_valid`, in, 1: execute-stage redirect (mispredict or trap).
- `i_redirect_pc`, in, `PC_WIDTH`: redirect target.
- `o_imem_req_valid`, out, 1: fetch request.
- `i_imem_req_ready`, in, 1: memory accepts the request.
- `o_imem_req_addr`, out, `PC_WIDTH`: fetch address.
- `i_imem_rsp_valid`, in, 1: response returned, in order. It is always accepted.
- `i_imem_rsp_data`, in, `INST_WIDTH`: fetched instruction.
- `o_valid`, out, 1: an entry is available to ID.
- `i_ready`, in, 1: ID accepts the entry.
- `o_pc`, out, `PC_WIDTH`: PC of the head entry.
- `o_inst`, out, `INST_WIDTH`: instruction of the head entry.
- `o_branch_predict`, out, 1: the head entry was predicted taken.

## Operation
- **State**
  - `fetch_pc`.
  - 2-entry in-flight PC FIFO.
  - `outstanding` counter, 0..2.
  - `kill` counter, 0..2.
  - 2-entry output FIFO holding `{pc, inst, pred}`.
- **Issue rule**
  - Condition: `o_imem_req_valid = !rst & !i_redirect_valid & !pred_taken_now & (occ + outstanding - pop) < 2`, where `pop = o_valid & i_ready`.
  - Valid may drop without acceptance; the memory side tolerates this.
  - On accept: push `fetch_pc` into the in-flight FIFO, `outstanding++`, `fetch_pc += 4`.
- **Response**
  - Each response pops the in-flight FIFO head and decrements `outstanding`.
  - If `kill > 0`: `kill--` and the data is discarded.
  - Otherwise the entry is pushed to the output FIFO. Space is guaranteed by the credit rule, so overflow is illegal; assert on it.
- **Prediction (combinational on accepted, non-killed response data)**
  - B-type (opcode `1100011`) with imm[12]=1: predict taken, target = pc + sext(B-imm).
  - JAL (opcode `1101111`): predict taken, target = pc + sext(J-imm).
  - All others: not taken; `pred` = 0.
- **Predicted-taken response (`pred_taken_now`)**
  - `fetch_pc <= target`.
  - `kill <= outstanding - 1`, i.e. the younger in-flight requests.
  - No request is issued that cycle.
  - The entry itself is kept, with `pred` = 1.
- **Redirect (highest priority)**
  - Output FIFO is cleared.
  - `fetch_pc <= i_redirect_pc`.
  - `kill <= outstanding - (i_imem_rsp_valid ? 1 : 0)`.
  - A response arriving in the redirect cycle is discarded.
  - Prediction is ignored and no request is issued.
  - `pop` in the redirect cycle is still a valid transfer to ID; ID is responsible for its own flush.
- **Simultaneous events**
  - Push and pop in the same cycle are allowed at any occupancy.
  - A redirect overrides a predicted-taken response in the same cycle.

## Timing
- **Reset values**
  - `o_valid` = 0, `o_imem_req_valid` = 0, `o_pc` = 0, `o_inst` = 0, `o_branch_predict` = 0.
  - `fetch_pc` = `RESET_PC`; all counters 0; both FIFOs empty.
- **Mid-operation reset:** all in-flight requests are forgotten. Responses arriving after reset deasserts with `outstanding` = 0 are ignored.
- **First request:** the first cycle after `rst` deasserts, with address `RESET_PC`.
- **Latency:** response accepted in cycle N gives `o_valid` = 1 in N+1 (registered output FIFO; no bypass).
- **Throughput:** 1 instruction per cycle with 1-cycle memory and `i_ready` held high.
- **Handshake to ID:** `o_pc`, `o_inst`, `o_branch_predict` are stable while `o_valid & !i_ready`.
- **Redirect:** asserted in cycle N gives `o_valid` = 0 in N+1 and a request to `i_redirect_pc` in N+1 if credits permit.
- **Wrap-around:** `fetch_pc` wraps modulo 2^`PC_WIDTH`; no fault is raised.

## Test plan
- **Reset then stream:** release reset with 1-cycle memory and `i_ready` = 1.
  - Addresses `0x8000_0000`, `0x8000_0004`, `0x8000_0008` are issued on consecutive cycles.
  - `o_valid` first rises 2 cycles after the first request.
- **ID stall:** hold `i_ready` = 0 for 10 cycles.
  - Exactly 2 requests are issued, then `o_imem_req_valid` = 0.
  - Head stays at `pc` = `0x8000_0000` until `i_ready` returns.
- **Redirect with 2 outstanding (memory latency 3):** assert a redirect to `0x8000_0100`.
  - Both old responses are dropped.
  - The next `o_pc` is `0x8000_0100`.
- **Backward branch:** `inst` `0xFE000EE3` (beq, imm −4) at `0x8000_0010`.
  - `o_branch_predict` = 1.
  - The next fetch is `0x8000_000C`.
  - The younger response for `0x8000_0014` is discarded.
- **Forward branch / JAL:** forward beq `+8` gives pred = 0 and sequential fetch. JAL `+0x20` at `0x8000_0000` gives pred = 1 and next fetch `0x8000_0020`.
- **Redirect and predicted-taken response in the same cycle:** the redirect target wins, and the response entry never appears at the output.
